// File: rtl/tone_gen_if.sv
// Note-request channel between the melody sequencer (master) and tone_gen (slave).
interface tone_gen_if #(
  parameter int PW = 12,
  parameter int DW = 8
) ();
  logic          note_valid;
  logic          note_ready;
  logic [PW-1:0] note_period;
  logic [DW-1:0] note_dur;

  modport master (
    output note_valid,
    output note_period,
    output note_dur,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_period,
    input  note_dur,
    output note_ready
  );
endinterface

// File: rtl/tone_gen.sv
// Square-wave note generator; duration counted in ticks where the counter value is all ones.
// Defining TONE_GEN_QUEUE_EN adds a one-entry note holding register for gapless melodies.
module tone_gen #(
  parameter int BW = 8,
  parameter int PW = 12,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] counter_val_i,
  tone_gen_if.slave     note_if,
  output logic          audio_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [1:0] {IDLE, PLAY, REST} state_e;

  localparam logic [PW-1:0] PER_ONE = PW'(1);
  localparam logic [DW-1:0] DUR_ONE = DW'(1);

  state_e        state_q, state_d;
  logic          audio_q, audio_d;
  logic          done_q, done_d;
  logic [PW-1:0] half_cnt_q, half_cnt_d;
  logic [DW-1:0] dur_cnt_q, dur_cnt_d;
  logic [PW-1:0] period_q, period_d;

  logic          tick;
  logic          accept;
  logic          fin;
  logic          ld_en;
  logic [PW-1:0] ld_period;
  logic [DW-1:0] ld_dur;

`ifdef TONE_GEN_QUEUE_EN
  logic          q_full_q, q_full_d;
  logic [PW-1:0] q_period_q, q_period_d;
  logic [DW-1:0] q_dur_q, q_dur_d;
  logic          done_pend_q, done_pend_d;
  logic          ld_chain;

  assign note_if.note_ready = !rst_i && !q_full_q;
`else
  assign note_if.note_ready = !rst_i && (state_q == IDLE);
`endif

  assign tick   = (counter_val_i == {BW{1'b1}});
  assign accept = note_if.note_valid && note_if.note_ready;

  always_comb begin
    state_d    = state_q;
    audio_d    = audio_q;
    done_d     = 1'b0;
    half_cnt_d = half_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    period_d   = period_q;
    fin        = 1'b0;
    ld_en      = 1'b0;
    ld_period  = note_if.note_period;
    ld_dur     = note_if.note_dur;
`ifdef TONE_GEN_QUEUE_EN
    q_full_d    = q_full_q;
    q_period_d  = q_period_q;
    q_dur_d     = q_dur_q;
    done_pend_d = 1'b0;
    done_d      = done_pend_q;
    ld_chain    = 1'b0;
`endif

    unique case (state_q)
      IDLE: ld_en = accept;
      PLAY: begin
        if (half_cnt_q == period_q - PER_ONE) begin
          audio_d    = !audio_q;
          half_cnt_d = '0;
        end else begin
          half_cnt_d = half_cnt_q + PER_ONE;
        end
      end
      default: ;
    endcase

    // A tick on the acceptance edge is naturally skipped: we are still IDLE there.
    if (state_q != IDLE && tick) begin
      if (dur_cnt_q == DUR_ONE) begin
        fin = 1'b1;
      end else begin
        dur_cnt_d = dur_cnt_q - DUR_ONE;
      end
    end

    if (fin) begin
      state_d    = IDLE;
      audio_d    = 1'b0;
      done_d     = 1'b1;
      half_cnt_d = '0;
      dur_cnt_d  = '0;
    end

`ifdef TONE_GEN_QUEUE_EN
    if (fin && q_full_q) begin
      ld_en     = 1'b1;
      ld_chain  = 1'b1;
      ld_period = q_period_q;
      ld_dur    = q_dur_q;
      q_full_d  = 1'b0;
    end else if (fin && accept) begin
      ld_en    = 1'b1;
      ld_chain = 1'b1;
    end else if (accept && state_q != IDLE) begin
      q_full_d   = 1'b1;
      q_period_d = note_if.note_period;
      q_dur_d    = note_if.note_dur;
    end
`endif

    if (ld_en) begin
      if (ld_dur == '0) begin
`ifdef TONE_GEN_QUEUE_EN
        // A zero-length note chained behind a completion gets its own pulse one cycle later.
        if (ld_chain) begin
          done_pend_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
`else
        done_d = 1'b1;
`endif
      end else begin
        state_d    = (ld_period == '0) ? REST : PLAY;
        period_d   = ld_period;
        half_cnt_d = '0;
        dur_cnt_d  = ld_dur;
        audio_d    = (ld_period != '0);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      audio_q    <= 1'b0;
      done_q     <= 1'b0;
      half_cnt_q <= '0;
      dur_cnt_q  <= '0;
`ifdef TONE_GEN_QUEUE_EN
      q_full_q    <= 1'b0;
      done_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      audio_q    <= audio_d;
      done_q     <= done_d;
      half_cnt_q <= half_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
`ifdef TONE_GEN_QUEUE_EN
      q_full_q    <= q_full_d;
      done_pend_q <= done_pend_d;
`endif
    end
  end

  // Note payload registers carry no control meaning until a valid state selects them.
  always_ff @(posedge clk_i) begin
    period_q <= period_d;
`ifdef TONE_GEN_QUEUE_EN
    q_period_q <= q_period_d;
    q_dur_q    <= q_dur_d;
`endif
  end

  assign audio_o = audio_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;

endmodule

// File: tb/tb_tone_gen.sv
// Randomized bench for tone_gen against a note-level reference model.
module tb_tone_gen;
  localparam int BW = 8;
  localparam int PW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] cnt = '0;
  logic          audio, busy, done;

  int n_chk = 0;
  int n_err = 0;

  tone_gen_if #(.PW(PW), .DW(DW)) nif ();

  tone_gen #(.BW(BW), .PW(PW), .DW(DW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .counter_val_i (cnt),
    .note_if       (nif),
    .audio_o       (audio),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = !clk;
  always @(posedge clk) cnt <= cnt + 8'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a note is (start cycle, half-period, ticks left).
  int cyc = 0;
  bit m_busy = 0, m_done = 0, m_audio = 0;
  int m_period = 0, m_start = 0, m_left = 0;
`ifdef TONE_GEN_QUEUE_EN
  bit m_qv = 0, m_pend = 0;
  int m_qp = 0, m_qd = 0;
`endif

  function automatic bit m_ready();
`ifdef TONE_GEN_QUEUE_EN
    return !rst && !m_qv;
`else
    return !rst && !m_busy;
`endif
  endfunction

  task automatic m_launch(input int p, input int d, input bit chained);
    if (d == 0) begin
`ifdef TONE_GEN_QUEUE_EN
      if (chained) m_pend = 1'b1;
      else m_done = 1'b1;
`else
      if (!chained) m_done = 1'b1;
`endif
    end else begin
      m_busy   = 1'b1;
      m_period = p;
      m_start  = cyc;
      m_left   = d;
    end
  endtask

  always @(posedge clk) begin
    bit acc, was_busy, fin;
    int p, d;
    cyc++;
    acc      = nif.note_valid && m_ready();
    p        = int'(nif.note_period);
    d        = int'(nif.note_dur);
    was_busy = m_busy;
    fin      = 1'b0;
    m_done   = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
`ifdef TONE_GEN_QUEUE_EN
      m_qv   = 1'b0;
      m_pend = 1'b0;
`endif
    end else begin
`ifdef TONE_GEN_QUEUE_EN
      m_done = m_pend;
      m_pend = 1'b0;
`endif
      if (m_busy && cnt == 8'hFF) begin
        m_left--;
        if (m_left == 0) fin = 1'b1;
      end
      if (fin) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
      if (acc && !was_busy) m_launch(p, d, 1'b0);
`ifdef TONE_GEN_QUEUE_EN
      else if (fin && m_qv) begin
        m_qv = 1'b0;
        m_launch(m_qp, m_qd, 1'b1);
      end else if (fin && acc) m_launch(p, d, 1'b1);
      else if (acc) begin
        m_qv = 1'b1;
        m_qp = p;
        m_qd = d;
      end
`endif
    end
    m_audio = 1'b0;
    if (m_busy && m_period != 0) m_audio = (((cyc - m_start) / m_period) % 2) == 0;
  end

  always @(posedge clk) begin
    #2;
    chk("audio", audio, m_audio);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("ready", nif.note_ready, m_ready());
  end

  task automatic send(input int p, input int d);
    int n = 0;
    @(negedge clk);
    nif.note_valid  = 1'b1;
    nif.note_period = PW'(p);
    nif.note_dur    = DW'(d);
    while (!nif.note_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", nif.note_ready, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      nif.note_valid  = 1'b0;
      nif.note_period = PW'($urandom);
      nif.note_dur    = DW'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      idle(1);
      n++;
    end
    chk("idle_wait", busy, 1'b0);
    idle(3);
  endtask

  initial begin
    int n;
    rst             = 1'b1;
    nif.note_valid  = 1'b0;
    nif.note_period = '0;
    nif.note_dur    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    send(5, 4);
    idle(20);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(30);

    send(4, 2);
    idle(1);
    wait_idle();

    send(0, 1);
    idle(1);
    wait_idle();
    send(7, 0);
    idle(4);

    send(1, 1);
    send(3, 1);
    idle(1);
    wait_idle();

`ifdef TONE_GEN_QUEUE_EN
    send(3, 1);
    send(2, 1);
    send(4, 1);
    idle(1);
    wait_idle();
`endif

    n = 0;
    while (cnt != 8'd254 && n < 300) begin
      idle(1);
      n++;
    end
    send(6, 1);
    idle(1);
    wait_idle();

    repeat (25) begin
      send(int'($urandom_range(0, 9)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 6)));
    end
    idle(1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
# tone_gen

Square-wave note generator that sits directly downstream of the free-running `counter` in the sound generator. It accepts note requests (half-period, duration) over a valid/ready handshake and drives a 1-bit audio output. Note length is measured in timebase ticks derived from the counter value. `busy_o` and a one-cycle `done_o` pulse let the upstream sequencer pace the melody.

## Interface
- `BW`, 8: width of the timebase counter value consumed.
- `PW`, 12: width of the half-period field, in clock cycles.
- `DW`, 8: width of the duration field, in timebase ticks.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `counter_val_i`  in  BW  timebase value from the counter.
- `note_valid_i`  in  1  note request valid.
- `note_ready_o`  out  1  block can accept a note this cycle.
- `note_period_i`  in  PW  half-period in clocks; 0 means rest (silence).
- `note_dur_i`  in  DW  duration in ticks.
- `audio_o`  out  1  square-wave output, registered.
- `busy_o`  out  1  a note or rest is in progress.
- `done_o`  out  1  one-cycle pulse when a note/rest completes.

## Operation
- Tick:
  - tick = (`counter_val_i` == {BW{1}}).
  - With `BW`=8 this gives one tick per 256 clocks when the counter free-runs.
- Handshake: a note is accepted on a rising edge where `note_valid_i` && `note_ready_o`. `note_period_i`/`note_dur_i` are sampled only then.
- FSM states:
  - IDLE: `busy_o`=0, `audio_o`=0.
  - PLAY: period ≠ 0.
  - REST: period = 0, `audio_o` held 0.
- IDLE → PLAY/REST on acceptance with dur ≠ 0.
- Accept with dur = 0:
  - Stays IDLE.
  - `done_o` pulses the next cycle.
  - `audio_o` is never driven high.
- On acceptance into PLAY:
  - `period_q` ← `note_period_i`.
  - `half_cnt` ← 0.
  - `audio_o` ← 1.
  - `dur_cnt` ← `note_dur_i`.
- PLAY, every cycle:
  - If `half_cnt` == `period_q`−1, then toggle `audio_o` and `half_cnt` ← 0.
  - Else `half_cnt` +1.
  - Output period is 2·`period_q` clocks at 50% duty.
  - `period_q`=1 toggles every cycle.
- PLAY/REST, duration:
  - On each tick, `dur_cnt` −1.
  - A tick coinciding with the acceptance edge is ignored.
  - On a tick with `dur_cnt` == 1:
    - State → IDLE (or the next note, see Configuration).
    - `audio_o` ← 0.
    - `done_o` pulses for 1 cycle.
- Arithmetic: counters are unsigned; `half_cnt` is PW bits and `dur_cnt` is DW bits. The compare-based reload means they never wrap.
- `note_ready_o` = (state == IDLE) in the base configuration.
- Reset at any time:
  - State → IDLE.
  - `audio_o`, `busy_o`, `done_o`, all counters → 0.
  - Queue cleared.
  - `note_ready_o` is 0 during reset and 1 in the first cycle after reset.

## Timing
- Acceptance at edge N:
  - `busy_o`=1 and `audio_o`=1 (PLAY) from N+1.
  - First toggle at edge N+`period_q`.
- Completion tick at edge M: `audio_o`=0, `busy_o`=0 and `done_o`=1 in cycle M+1. `done_o`=0 again at M+2.
- Base config: `note_ready_o` rises at M+1, so the earliest next acceptance is at edge M+1.
- Simultaneous tick and toggle on the final cycle: completion wins and `audio_o` goes to 0.
- Changes on `note_period_i`/`note_dur_i` while a note is active have no effect.

## Configuration
- `TONE_GEN_QUEUE_EN` defined:
  - Adds a one-entry holding register.
  - `note_ready_o` = !queue_full.
  - Accept in IDLE with the queue empty: starts the note directly and bypasses the queue.
  - Accept while busy: stores the note in the queue.
  - At completion with the queue full:
    - The queued note starts on the same edge; PLAY/REST is reloaded with `audio_o` ← 1 for PLAY.
    - There is no IDLE cycle and `busy_o` stays 1.
    - `done_o` still pulses.
    - Queue slot frees at that edge.
  - A queued dur = 0 entry completes immediately with its own `done_o` pulse on the following cycle.
- `TONE_GEN_QUEUE_EN` undefined: no queue; `note_ready_o` = (state == IDLE).

## Test plan
- Reset:
  - Stimulus: assert `rst_i` 3 cycles mid-note (period 5, dur 4).
  - Required: next cycle `audio_o`=0, `busy_o`=0, `done_o`=0, `note_ready_o`=1 after release, and no further toggles.
- Basic tone:
  - Stimulus: `BW`=8 with the counter free-running from 0; accept period 4, dur 2 at cycle 10.
  - Required:
    - `audio_o` high 4 / low 4 repeating.
    - The first tick (counter=255, not the acceptance cycle) decrements the duration.
    - The second tick ends the note.
    - `done_o` is a single-cycle pulse and `audio_o`=0 after it.
- Rest and zero duration:
  - Stimulus 1: period 0, dur 1. Required: `busy_o`=1 until the tick, `audio_o` stays 0, one `done_o`.
  - Stimulus 2: period 7, dur 0. Required: `done_o` the cycle after acceptance, `busy_o` never 1.
- Period 1 and back-pressure:
  - Stimulus: period 1; hold `note_valid_i` high with a second note.
  - Required:
    - `audio_o` toggles every clock.
    - Base config: the second note is accepted exactly the cycle after `done_o`, and `note_ready_o`=0 throughout PLAY.
- Queue (`TONE_GEN_QUEUE_EN`):
  - Stimulus: accept A (period 3, dur 1), then B (period 2, dur 1) while A plays; offer a third note C while B is queued.
  - Required:
    - `note_ready_o`=0 after B is queued, so C is held off.
    - At A's completion: `done_o` pulses, `busy_o` stays 1, and `audio_o` restarts high with period 2.
- Tick at acceptance:
  - Stimulus: accept dur 1 on the cycle where `counter_val_i`=255.
  - Required: that tick is ignored, and the note ends on the following tick 256 clocks later.
